// File: rtl/reg_bank_pkg.sv
// reg_bank_pkg: default sizing constants shared by the register bank files.
package reg_bank_pkg;
    localparam int WIDTH_D  = 64;
    localparam int DEPTH_D  = 32;
    localparam int AW_D     = $clog2(DEPTH_D);
    localparam int NUM_RD_D = 2;
    localparam int ZERO_IDX = 0;
endpackage

// File: rtl/reg_bank_sb_entry.sv
// reg_entry: one WIDTH-bit register with load enable and synchronous reset.
module reg_entry #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);
    logic [WIDTH-1:0] r_q;
    always_ff @(posedge clk) begin
        if (rst) r_q <= '0;
        else if (i_load) r_q <= i_d;
    end
    assign o_q = r_q;
endmodule

// File: rtl/reg_bank_sb.sv
// reg_bank_sb: multi-read-port register bank with write-through bypass and
// a per-register pending bit for RAW/WAW hazard detection at issue.
module reg_bank_sb
    import reg_bank_pkg::*;
#(
    parameter int WIDTH    = WIDTH_D,
    parameter int DEPTH    = DEPTH_D,
    parameter int AW       = AW_D,
    parameter int NUM_RD   = NUM_RD_D,
    parameter int ZERO_REG = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_RD*AW-1:0]    i_rd_addr,
    output logic [NUM_RD*WIDTH-1:0] o_rd_data,
    output logic [NUM_RD-1:0]       o_rd_busy,
    input  logic                    i_we,
    input  logic [AW-1:0]           i_wr_addr,
    input  logic [WIDTH-1:0]        i_wr_data,
    input  logic                    i_iss_valid,
    input  logic [AW-1:0]           i_iss_addr,
    output logic                    o_iss_stall
);
    logic [WIDTH-1:0] w_mem [DEPTH];
    logic [DEPTH-1:0] r_pend;
    logic             w_stall;
    // A writeback landing on the issue target this cycle frees it, so no stall.
    assign w_stall     = i_iss_valid && r_pend[i_iss_addr] && !(i_we && i_wr_addr == i_iss_addr);
    assign o_iss_stall = w_stall;
    genvar g, p;
    generate
        for (g = 0; g < DEPTH; g++) begin : g_reg
            reg_entry #(.WIDTH(WIDTH)) u_reg (
                .clk    (clk),
                .rst    (rst),
                .i_load (i_we && i_wr_addr == AW'(g) && !(ZERO_REG != 0 && g == ZERO_IDX)),
                .i_d    (i_wr_data),
                .o_q    (w_mem[g])
            );
        end
    endgenerate
    // Accepted issue sets pending and wins over a same-cycle writeback clear.
    always_ff @(posedge clk) begin
        if (rst) r_pend <= '0;
        else
            for (int i = 0; i < DEPTH; i++)
                if (i_iss_valid && !w_stall && i_iss_addr == AW'(i) && !(ZERO_REG != 0 && i == ZERO_IDX))
                    r_pend[i] <= 1'b1;
                else if (i_we && i_wr_addr == AW'(i))
                    r_pend[i] <= 1'b0;
    end
    generate
        for (p = 0; p < NUM_RD; p++) begin : g_rd
            logic [AW-1:0] w_ra;
            logic          w_zero;
            logic          w_byp;
            assign w_ra   = i_rd_addr[p*AW +: AW];
            assign w_zero = ZERO_REG != 0 && w_ra == AW'(ZERO_IDX);
            assign w_byp  = i_we && i_wr_addr == w_ra;
            assign o_rd_data[p*WIDTH +: WIDTH] = w_zero ? '0 : w_byp ? i_wr_data : w_mem[w_ra];
            assign o_rd_busy[p] = !w_zero && !w_byp && r_pend[w_ra];
        end
    endgenerate
endmodule

// File: tb/tb_reg_bank_sb.sv
// tb_reg_bank_sb: directed stimulus with a queue scoreboard; a negedge monitor
// drains expectations pushed during the current cycle and compares outputs.
module tb_reg_bank_sb;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [9:0]   rd_addr = '0;
    logic [127:0] rd_data;
    logic [1:0]   rd_busy;
    logic         we = 1'b0;
    logic [4:0]   wr_addr = '0;
    logic [63:0]  wr_data = '0;
    logic         iss_valid = 1'b0;
    logic [4:0]   iss_addr = '0;
    logic         iss_stall;
    int           n_run = 0;
    int           n_fail = 0;

    typedef struct {
        string       nm;
        logic [63:0] d0;
        logic [63:0] d1;
        logic [1:0]  b;
        logic        s;
    } exp_t;
    exp_t q[$];

    reg_bank_sb dut (
        .clk         (clk),
        .rst         (rst),
        .i_rd_addr   (rd_addr),
        .o_rd_data   (rd_data),
        .o_rd_busy   (rd_busy),
        .i_we        (we),
        .i_wr_addr   (wr_addr),
        .i_wr_data   (wr_data),
        .i_iss_valid (iss_valid),
        .i_iss_addr  (iss_addr),
        .o_iss_stall (iss_stall)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_run++;
            if (rd_data[63:0] !== e.d0 || rd_data[127:64] !== e.d1 || rd_busy !== e.b || iss_stall !== e.s) begin
                n_fail++;
                $display("FAIL %s: got d0=%h d1=%h busy=%b stall=%b, expected d0=%h d1=%h busy=%b stall=%b",
                         e.nm, rd_data[63:0], rd_data[127:64], rd_busy, iss_stall, e.d0, e.d1, e.b, e.s);
            end
        end
    end

    task automatic cyc(input logic r, input logic w, input logic [4:0] wa, input logic [63:0] wd,
                       input logic v, input logic [4:0] ia, input logic [4:0] ra0, input logic [4:0] ra1);
        @(posedge clk);
        #1;
        rst = r; we = w; wr_addr = wa; wr_data = wd;
        iss_valid = v; iss_addr = ia; rd_addr = {ra1, ra0};
    endtask

    task automatic expect_out(input string nm, input logic [63:0] d0, input logic [63:0] d1,
                              input logic [1:0] b, input logic s);
        q.push_back('{nm: nm, d0: d0, d1: d1, b: b, s: s});
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running required finished");
        $fatal(1);
    end

    initial begin
        // args: rst we wa wd iss_valid iss_addr ra0 ra1 ; expect: d0 d1 busy{p1,p0} stall
        cyc(0, 1, 1, 64'h11, 0, 0, 0, 0);             expect_out("reset_state", 0, 0, 2'b00, 0);
        cyc(0, 1, 2, 64'h22, 1, 6, 1, 2);             expect_out("wr_rd_bypass", 64'h11, 64'h22, 2'b00, 0);
        cyc(0, 1, 5, 64'h55, 0, 0, 6, 5);             expect_out("pend6_byp5", 0, 64'h55, 2'b01, 0);
        cyc(0, 1, 8, 64'h88, 0, 0, 1, 5);             expect_out("pre_reset", 64'h11, 64'h55, 2'b00, 0);
        cyc(1, 1, 6, 64'h66, 1, 1, 1, 5);
        cyc(0, 0, 0, 0, 0, 0, 1, 5);                  expect_out("after_rst_a", 0, 0, 2'b00, 0);
        cyc(0, 0, 0, 0, 1, 6, 6, 8);                  expect_out("after_rst_b", 0, 0, 2'b00, 0);
        cyc(0, 0, 0, 0, 1, 6, 6, 6);                  expect_out("waw_stall6", 0, 0, 2'b11, 1);
        cyc(0, 1, 7, 64'hDEAD_BEEF, 0, 0, 7, 7);      expect_out("byp7", 64'hDEAD_BEEF, 64'hDEAD_BEEF, 2'b00, 0);
        cyc(0, 0, 0, 0, 0, 0, 7, 7);                  expect_out("rd7", 64'hDEAD_BEEF, 64'hDEAD_BEEF, 2'b00, 0);
        cyc(0, 1, 0, 64'h1234, 1, 0, 0, 0);           expect_out("zero_wr_iss", 0, 0, 2'b00, 0);
        cyc(0, 0, 0, 0, 1, 0, 0, 7);                  expect_out("zero_after", 0, 64'hDEAD_BEEF, 2'b00, 0);
        cyc(0, 0, 0, 0, 1, 3, 3, 0);                  expect_out("iss3", 0, 0, 2'b00, 0);
        cyc(0, 0, 0, 0, 1, 3, 3, 7);                  expect_out("waw3", 0, 64'hDEAD_BEEF, 2'b01, 1);
        cyc(0, 0, 0, 0, 0, 0, 3, 3);                  expect_out("hold3", 0, 0, 2'b11, 0);
        cyc(0, 1, 3, 64'h55, 0, 0, 3, 7);             expect_out("wb3_byp", 64'h55, 64'hDEAD_BEEF, 2'b00, 0);
        cyc(0, 0, 0, 0, 0, 0, 3, 3);                  expect_out("wb3_done", 64'h55, 64'h55, 2'b00, 0);
        cyc(0, 0, 0, 0, 1, 9, 9, 0);                  expect_out("iss9", 0, 0, 2'b00, 0);
        cyc(0, 1, 9, 64'h99, 1, 9, 9, 3);             expect_out("sim9", 64'h99, 64'h55, 2'b00, 0);
        cyc(0, 0, 0, 0, 0, 0, 9, 9);                  expect_out("sim9_after", 64'h99, 64'h99, 2'b11, 0);
        cyc(0, 0, 0, 0, 1, 4, 4, 9);                  expect_out("iss4", 0, 64'h99, 2'b10, 0);
        cyc(1, 1, 4, 64'hAA, 0, 0, 4, 4);             expect_out("rst_cycle_byp", 64'hAA, 64'hAA, 2'b00, 0);
        cyc(0, 0, 0, 0, 1, 9, 4, 9);                  expect_out("rst_mid", 0, 0, 2'b00, 0);
        cyc(0, 0, 0, 0, 0, 0, 4, 9);                  expect_out("post_rst_iss9", 0, 0, 2'b10, 0);
        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expectations, required 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
